// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared constants and enums for the register file write scheduler
package rf_sched_pkg;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} stateT;
    typedef enum logic {GNT_A, GNT_B} grantT;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter, one-hot grant {B, A}
module rr_arbiter2
    import rf_sched_pkg::*;
(
    input  logic       aValid,
    input  logic       bValid,
    input  logic       enable,
    input  grantT      lastGrant,
    output logic [1:0] grant
);
    // The requester that did not win last time takes any contention.
    always_comb begin
        grant    = 2'b00;
        grant[0] = enable & aValid & (~bValid | (lastGrant == GNT_B));
        grant[1] = enable & bValid & (~aValid | (lastGrant == GNT_A));
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - write-port owner: A/B writeback arbitration plus X0..X30 bulk clear; RFSCHED_BYPASS_EN adds read bypass
module regfile_write_scheduler #(
    parameter int                   DATA_W    = rf_sched_pkg::DATA_W,
    parameter int                   ADDR_W    = rf_sched_pkg::ADDR_W,
    parameter int                   ZERO_REG  = rf_sched_pkg::ZERO_REG,
    parameter logic [DATA_W-1:0]    CLR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              resetl,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rw,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rw,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
`ifdef RFSCHED_BYPASS_EN
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] BusA_in,
    input  logic [DATA_W-1:0] BusB_in,
    output logic [DATA_W-1:0] BusA_out,
    output logic [DATA_W-1:0] BusB_out,
`endif
    output logic              RegWr
);
    import rf_sched_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ZERO_REG - 1);

    stateT             state, nextState;
    grantT             lastGrant;
    logic [ADDR_W-1:0] clrIdx;
    logic [1:0]        grant;
    logic              arbEnable;

    assign arbEnable = (state == IDLE) & ~clr_req;

    rr_arbiter2 uArb (
        .aValid    (a_valid),
        .bValid    (b_valid),
        .enable    (arbEnable),
        .lastGrant (lastGrant),
        .grant     (grant)
    );

    always_comb begin
        nextState = state;
        a_ready   = grant[0];
        b_ready   = grant[1];
        clr_busy  = (state != IDLE);
        clr_done  = (state == DONE);
        case (state)
            IDLE:    if (clr_req) nextState = CLEAR;
            CLEAR:   if (clrIdx == LAST_IDX) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!resetl) begin
            state     <= IDLE;
            lastGrant <= GNT_B;
            clrIdx    <= '0;
            RW        <= '0;
            BusW      <= '0;
            RegWr     <= 1'b0;
        end else begin
            state <= nextState;
            RegWr <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        clrIdx <= '0;
                        RW     <= '0;
                        BusW   <= CLR_VALUE;
                        RegWr  <= 1'b1;
                    end else if (grant[0]) begin
                        RW        <= a_rw;
                        BusW      <= a_data;
                        RegWr     <= (a_rw != ZERO_IDX);
                        lastGrant <= GNT_A;
                    end else if (grant[1]) begin
                        RW        <= b_rw;
                        BusW      <= b_data;
                        RegWr     <= (b_rw != ZERO_IDX);
                        lastGrant <= GNT_B;
                    end
                end
                CLEAR: begin
                    // The sweep stops one short of XZR, so clrIdx never wraps.
                    if (clrIdx != LAST_IDX) begin
                        clrIdx <= clrIdx + 1'b1;
                        RW     <= clrIdx + 1'b1;
                        RegWr  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RFSCHED_BYPASS_EN
    always_comb begin
        BusA_out = (RegWr && (RW == RA) && (RA != ZERO_IDX)) ? BusW : BusA_in;
        BusB_out = (RegWr && (RW == RB) && (RB != ZERO_IDX)) ? BusW : BusB_in;
    end
`endif
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - directed and randomized self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;
    logic        Clk = 1'b0;
    logic        resetl = 1'b0;
    logic        clr_req = 1'b0;
    logic        clr_busy, clr_done;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_rw = '0, b_rw = '0;
    logic [63:0] a_data = '0, b_data = '0;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
`ifdef RFSCHED_BYPASS_EN
    logic [4:0]  RA = '0, RB = '0;
    logic [63:0] BusA_in = '0, BusB_in = '0;
    logic [63:0] BusA_out, BusB_out;
`endif

    int total = 0;
    int bad   = 0;

    regfile_write_scheduler dut (
        .Clk(Clk), .resetl(resetl), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .a_valid(a_valid), .a_ready(a_ready), .a_rw(a_rw), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_data(b_data),
        .RW(RW), .BusW(BusW),
`ifdef RFSCHED_BYPASS_EN
        .RA(RA), .RB(RB), .BusA_in(BusA_in), .BusB_in(BusB_in),
        .BusA_out(BusA_out), .BusB_out(BusB_out),
`endif
        .RegWr(RegWr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Reference model: sweep position -1 = idle, 0..30 = clear write of that
    // register is visible, 31 = done cycle. Grant history: 0 = A won last, 1 = B.
    int          mSweep = -1;
    bit          mLastB = 1'b1;
    bit          checkOn = 1'b0;
    logic [4:0]  expRW = '0;
    logic [63:0] expBusW = '0;
    bit          expRegWr = 1'b0;

    always @(negedge Clk) begin
        bit idle, expA, expB;
        idle = (mSweep == -1);
        expA = idle && !clr_req && a_valid && (!b_valid || mLastB);
        expB = idle && !clr_req && b_valid && (!a_valid || !mLastB);
        if (checkOn) begin
            chk("m_a_ready", a_ready, expA);
            chk("m_b_ready", b_ready, expB);
            chk("m_clr_busy", clr_busy, !idle);
            chk("m_clr_done", clr_done, mSweep == 31);
            chk("m_RegWr", RegWr, expRegWr);
            chk("m_RW", RW, expRW);
            chk("m_BusW", BusW, expBusW);
`ifdef RFSCHED_BYPASS_EN
            chk("m_BusA_out", BusA_out,
                (expRegWr && expRW == RA && RA != 5'd31) ? expBusW : BusA_in);
            chk("m_BusB_out", BusB_out,
                (expRegWr && expRW == RB && RB != 5'd31) ? expBusW : BusB_in);
`endif
        end
        if (!resetl) begin
            checkOn  = 1'b1;
            mSweep   = -1;
            mLastB   = 1'b1;
            expRW    = '0;
            expBusW  = '0;
            expRegWr = 1'b0;
        end else if (idle) begin
            expRegWr = 1'b0;
            if (clr_req) begin
                mSweep = 0; expRW = 5'd0; expBusW = '0; expRegWr = 1'b1;
            end else if (expA) begin
                expRW = a_rw; expBusW = a_data; expRegWr = (a_rw != 5'd31); mLastB = 1'b0;
            end else if (expB) begin
                expRW = b_rw; expBusW = b_data; expRegWr = (b_rw != 5'd31); mLastB = 1'b1;
            end
        end else if (mSweep < 30) begin
            mSweep++;
            expRW = 5'(mSweep); expRegWr = 1'b1;
        end else if (mSweep == 30) begin
            mSweep = 31; expRegWr = 1'b0;
        end else begin
            mSweep = -1; expRegWr = 1'b0;
        end
    end

    task automatic doReset;
        resetl = 1'b0;
        tick;
        resetl = 1'b1;
    endtask

    initial begin
        doReset;
        chk("rst_RW", RW, 0);
        chk("rst_BusW", BusW, 0);
        chk("rst_RegWr", RegWr, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);

        // A alone
        a_valid = 1; a_rw = 5; a_data = 64'h12345678; #1;
        chk("a_solo_ready", a_ready, 1);
        tick; a_valid = 0;
        chk("a_solo_RW", RW, 5);
        chk("a_solo_BusW", BusW, 64'h12345678);
        chk("a_solo_RegWr", RegWr, 1);
        tick;
        chk("a_solo_RegWr_drop", RegWr, 0);

        // Contention alternates starting with A after reset
        doReset;
        a_valid = 1; a_rw = 1; a_data = 64'h11;
        b_valid = 1; b_rw = 2; b_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2) == 0);
            chk("rr_b_ready", b_ready, (i % 2) == 1);
            tick;
            chk("rr_RW", RW, ((i % 2) == 0) ? 1 : 2);
        end
        a_valid = 0; b_valid = 0;

        // XZR write: accepted, not written, still takes the turn
        a_valid = 1; a_rw = 31; a_data = 64'hFFFF; #1;
        chk("xzr_ready", a_ready, 1);
        tick;
        chk("xzr_RW", RW, 31);
        chk("xzr_RegWr", RegWr, 0);
        b_valid = 1; b_rw = 4; #1;
        chk("xzr_turn_b", b_ready, 1);
        chk("xzr_turn_a", a_ready, 0);
        a_valid = 0; b_valid = 0;
        tick;

        // Bulk clear with A waiting
        a_valid = 1; a_rw = 3; a_data = 64'h33; clr_req = 1; #1;
        chk("clr_a_blocked", a_ready, 0);
        tick; clr_req = 0;
        for (int i = 0; i < 31; i++) begin
            chk("clr_RW", RW, i);
            chk("clr_RegWr", RegWr, 1);
            chk("clr_BusW", BusW, 0);
            chk("clr_a_ready", a_ready, 0);
            clr_req = (i == 5);
            tick;
        end
        clr_req = 0;
        chk("clr_done_pulse", clr_done, 1);
        chk("clr_done_RegWr", RegWr, 0);
        tick;
        chk("clr_done_low", clr_done, 0);
        chk("clr_idle_busy", clr_busy, 0);
        chk("clr_idle_a_ready", a_ready, 1);
        tick; a_valid = 0;

        // Reset aborts a sweep after the 10th write
        clr_req = 1; tick; clr_req = 0;
        for (int i = 0; i < 10; i++) begin
            chk("abort_RW", RW, i);
            if (i < 9) tick;
        end
        resetl = 0; tick; resetl = 1;
        chk("abort_RegWr", RegWr, 0);
        chk("abort_busy", clr_busy, 0);
        tick;
        chk("abort_quiet", RegWr, 0);
        clr_req = 1; tick; clr_req = 0;
        chk("restart_RW", RW, 0);
        chk("restart_RegWr", RegWr, 1);
        repeat (33) tick;
        chk("restart_idle", clr_busy, 0);

`ifdef RFSCHED_BYPASS_EN
        b_valid = 1; b_rw = 7; b_data = 64'hABC; RA = 7; BusA_in = 64'h1;
        tick; b_valid = 0;
        chk("byp_hit", BusA_out, 64'hABC);
        tick;
        chk("byp_after", BusA_out, 64'h1);
        a_valid = 1; a_rw = 31; a_data = 64'h5; RA = 31;
        tick; a_valid = 0;
        chk("byp_xzr", BusA_out, 64'h1);
`endif

        // Randomized traffic checked by the model
        for (int n = 0; n < 800; n++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 1));
            a_rw    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            b_rw    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            a_data  = {$urandom, $urandom};
            b_data  = {$urandom, $urandom};
            clr_req = ($urandom_range(0, 59) == 0);
            resetl  = ($urandom_range(0, 149) != 0);
`ifdef RFSCHED_BYPASS_EN
            RA = 5'($urandom_range(0, 31)); RB = 5'($urandom_range(0, 31));
            BusA_in = {$urandom, $urandom}; BusB_in = {$urandom, $urandom};
`endif
            tick;
        end
        a_valid = 0; b_valid = 0; clr_req = 0; resetl = 1;
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
